// File: rtl/serial_operand_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_operand_tx_pkg
//   Shared definitions for the serial FIR operand launcher: default operand and
//   frame-counter widths, frame length and the launcher FSM state encoding.
// -----------------------------------------------------------------------------
package serial_operand_tx_pkg;

    localparam int DEF_NB_DATA_IN = 4;                    // S(4,3) operands
    localparam int DEF_NB_COUNTER = 3;                    // frame index width
    localparam int DEF_FRAME_LEN  = 1 << DEF_NB_COUNTER;  // cycles per frame

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_operand_tx_piso.sv
// -----------------------------------------------------------------------------
// serial_operand_tx_piso
//   Parallel-load, LSB-first shift register with zero fill. A load places bit 0
//   on o_bit immediately (registered) and keeps the remaining bits. Each shift
//   presents the next bit. Once the operand is exhausted the output is 0.
//
// Ports
//   clk      in  1   clock, rising edge
//   i_rst    in  1   asynchronous reset, active low
//   i_en     in  1   enable; low holds all state
//   i_load   in  1   load i_data (takes priority over i_shift)
//   i_shift  in  1   advance to the next bit
//   i_data   in  NB  parallel operand
//   o_bit    out 1   current serial bit
// -----------------------------------------------------------------------------
module serial_operand_tx_piso #(
    parameter int NB = 4
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_load,
    input  logic          i_shift,
    input  logic [NB-1:0] i_data,
    output logic          o_bit
);

    // sh_q holds the bits not yet presented, LSB next; zeros shift in at the top
    logic [NB-1:0] sh_q;
    logic          bit_q;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            sh_q  <= '0;
            bit_q <= 1'b0;
        end else if (i_en) begin
            if (i_load) begin
                bit_q <= i_data[0];
                sh_q  <= i_data >> 1;
            end else if (i_shift) begin
                bit_q <= sh_q[0];
                sh_q  <= sh_q >> 1;
            end
        end
    end

    assign o_bit = bit_q;

endmodule

// File: rtl/serial_operand_tx.sv
// -----------------------------------------------------------------------------
// serial_operand_tx
//   Parallel-to-serial operand launcher for the serial FIR datapath. Accepts
//   sample/coefficient pairs over valid/ready and drives a bit-serial multiplier
//   LSB first, one frame of 2^NB_COUNTER cycles per pair. A one-entry pending
//   buffer lets frames run back-to-back with no gap.
//
// Configuration
//   SERIAL_TX_ZERO_FILL_EN  defined: once running, a frame with no pair
//                           available is launched as a zero frame so the tap
//                           stays phase-locked. Undefined: return to IDLE.
//
// Ports
//   clk            in  1           clock, rising edge
//   i_rst          in  1           asynchronous reset, active low
//   i_en           in  1           global enable; low freezes all state
//   i_sample       in  NB_DATA_IN  parallel operand a
//   i_coeff        in  NB_DATA_IN  parallel operand b
//   i_valid        in  1           pair valid
//   o_ready        out 1           pair accepted this cycle if valid
//   o_data_a       out 1           serial operand a bit
//   o_data_b       out 1           serial operand b bit
//   o_counter      out NB_COUNTER  frame bit index
//   o_mult_en      out 1           multiplier enable (frame active)
//   o_frame_start  out 1           high on counter==0 of an active frame
// -----------------------------------------------------------------------------
module serial_operand_tx
    import serial_operand_tx_pkg::*;
#(
    parameter int NB_DATA_IN = DEF_NB_DATA_IN,
    parameter int NB_COUNTER = DEF_NB_COUNTER   // 2^NB_COUNTER >= 2*NB_DATA_IN
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [NB_DATA_IN-1:0] i_sample,
    input  logic [NB_DATA_IN-1:0] i_coeff,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_data_a,
    output logic                  o_data_b,
    output logic [NB_COUNTER-1:0] o_counter,
    output logic                  o_mult_en,
    output logic                  o_frame_start
);

    localparam logic [NB_COUNTER-1:0] CNT_LAST = '1;

    state_t                  state_q, state_d;
    logic [NB_COUNTER-1:0]   cnt_q, cnt_d;
    logic                    pend_full_q, pend_full_d;
    logic [NB_DATA_IN-1:0]   pend_a_q, pend_a_d;
    logic [NB_DATA_IN-1:0]   pend_b_q, pend_b_d;
    logic                    mult_en_q, mult_en_d;
    logic                    fs_q, fs_d;

    logic                    xfer;
    logic                    load;
    logic                    shift;
    logic [NB_DATA_IN-1:0]   ld_a, ld_b;

    assign o_ready = i_en & ~pend_full_q;
    assign xfer    = i_valid & o_ready;

    // -------------------------------------------------------------------------
    // Next state. The register stage only advances when i_en is high, so the
    // values below describe an enabled cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_full_d = pend_full_q;
        pend_a_d    = pend_a_q;
        pend_b_d    = pend_b_q;
        mult_en_d   = mult_en_q;
        fs_d        = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        ld_a        = i_sample;
        ld_b        = i_coeff;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                mult_en_d = 1'b0;
                if (xfer) begin
                    load      = 1'b1;
                    state_d   = ST_RUN;
                    mult_en_d = 1'b1;
                    fs_d      = 1'b1;
                end
            end

            ST_RUN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d     = cnt_q + 1'b1;
                    shift     = 1'b1;
                    mult_en_d = 1'b1;
                    if (xfer) begin
                        pend_full_d = 1'b1;
                        pend_a_d    = i_sample;
                        pend_b_d    = i_coeff;
                    end
                end else begin
                    // End of frame: pending pair first, then a pair arriving
                    // right now (forwarded, pending stays empty).
                    cnt_d = '0;
                    if (pend_full_q) begin
                        load        = 1'b1;
                        ld_a        = pend_a_q;
                        ld_b        = pend_b_q;
                        pend_full_d = 1'b0;
                        mult_en_d   = 1'b1;
                        fs_d        = 1'b1;
                    end else if (xfer) begin
                        load      = 1'b1;
                        mult_en_d = 1'b1;
                        fs_d      = 1'b1;
                    end else begin
`ifdef SERIAL_TX_ZERO_FILL_EN
                        load      = 1'b1;
                        ld_a      = '0;
                        ld_b      = '0;
                        mult_en_d = 1'b1;
                        fs_d      = 1'b1;
`else
                        // Operands are exhausted, so one more shift parks the
                        // serial bits at zero.
                        shift     = 1'b1;
                        state_d   = ST_IDLE;
                        mult_en_d = 1'b0;
`endif
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                mult_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            pend_a_q    <= '0;
            pend_b_q    <= '0;
            mult_en_q   <= 1'b0;
            fs_q        <= 1'b0;
        end else if (i_en) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
            pend_a_q    <= pend_a_d;
            pend_b_q    <= pend_b_d;
            mult_en_q   <= mult_en_d;
            fs_q        <= fs_d;
        end
    end

    serial_operand_tx_piso #(.NB(NB_DATA_IN)) u_piso_a (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_load  (load),
        .i_shift (shift),
        .i_data  (ld_a),
        .o_bit   (o_data_a)
    );

    serial_operand_tx_piso #(.NB(NB_DATA_IN)) u_piso_b (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_load  (load),
        .i_shift (shift),
        .i_data  (ld_b),
        .o_bit   (o_data_b)
    );

    // A frozen block must not let the multiplier accumulate, so the enables
    // are qualified by i_en while the registers themselves hold.
    assign o_counter     = cnt_q;
    assign o_mult_en     = mult_en_q & i_en;
    assign o_frame_start = fs_q & i_en;

endmodule

// File: tb/tb_serial_operand_tx.sv
module tb_serial_operand_tx;

    localparam int NB   = 4;
    localparam int LAST = 7;   // last frame index (frame length 8)

    logic          clk = 1'b0;
    logic          i_rst, i_en, i_valid;
    logic [NB-1:0] i_sample, i_coeff;
    logic          o_ready, o_data_a, o_data_b, o_mult_en, o_frame_start;
    logic [2:0]    o_counter;

    serial_operand_tx dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_sample      (i_sample),
        .i_coeff       (i_coeff),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_data_a      (o_data_a),
        .o_data_b      (o_data_b),
        .o_counter     (o_counter),
        .o_mult_en     (o_mult_en),
        .o_frame_start (o_frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: frame position (-1 = idle), active pair, pending queue.
    int pos = -1;
    int cur_a = 0, cur_b = 0;
    int qa[$], qb[$];
    bit accepted;
    int run_len = 0, max_run = 0;

    function automatic int bit_of(input int v, input int p);
        if (p < 0 || p >= NB) return 0;
        return (v >> p) & 1;
    endfunction

    task automatic model_reset();
        pos = -1; cur_a = 0; cur_b = 0;
        qa.delete(); qb.delete();
    endtask

    task automatic model_update();
        bit xfer;
        accepted = 0;
        if (!i_rst) begin model_reset(); return; end
        if (!i_en) return;
        xfer = i_valid && (qa.size() == 0);
        accepted = xfer;
        if (pos < 0) begin
            if (xfer) begin cur_a = int'(i_sample); cur_b = int'(i_coeff); pos = 0; end
        end else if (pos < LAST) begin
            pos++;
            if (xfer) begin qa.push_back(int'(i_sample)); qb.push_back(int'(i_coeff)); end
        end else begin
            if (qa.size() != 0) begin
                cur_a = qa.pop_front(); cur_b = qb.pop_front(); pos = 0;
            end else if (xfer) begin
                cur_a = int'(i_sample); cur_b = int'(i_coeff); pos = 0;
            end else begin
`ifdef SERIAL_TX_ZERO_FILL_EN
                cur_a = 0; cur_b = 0; pos = 0;
`else
                pos = -1;
`endif
            end
        end
    endtask

    task automatic check_outputs();
        chk("ready",   32'(o_ready),       32'(i_en && qa.size() == 0));
        chk("mult_en", 32'(o_mult_en),     32'(pos >= 0 && i_en));
        chk("fstart",  32'(o_frame_start), 32'(pos == 0 && i_en));
        chk("counter", 32'(o_counter),     32'(pos < 0 ? 0 : pos));
        chk("data_a",  32'(o_data_a),      32'(bit_of(cur_a, pos)));
        chk("data_b",  32'(o_data_b),      32'(bit_of(cur_b, pos)));
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        if (o_mult_en) run_len++; else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_reset_values();
        chk("rst_data_a",  32'(o_data_a),      0);
        chk("rst_data_b",  32'(o_data_b),      0);
        chk("rst_counter", 32'(o_counter),     0);
        chk("rst_mult_en", 32'(o_mult_en),     0);
        chk("rst_fstart",  32'(o_frame_start), 0);
        chk("rst_ready",   32'(o_ready),       1);
    endtask

    // Hold a pair on the inputs until the model reports it accepted.
    task automatic offer(input logic [NB-1:0] a, input logic [NB-1:0] b);
        int n = 0;
        i_sample = a; i_coeff = b; i_valid = 1'b1;
        do begin cycle(); n++; end while (!accepted && n < 50);
        if (!accepted) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_pos(input int p, input int need_pend);
        int n = 0;
        while (!(pos == p && qa.size() >= need_pend) && n < 60) begin cycle(); n++; end
        if (n >= 60) chk("wait_pos_timeout", 0, 1);
    endtask

    initial begin
        i_rst = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_sample = '0; i_coeff = '0;
        #1;
        check_reset_values();
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b1;

        // Idle with no traffic
        repeat (20) cycle();

        // Single pair, then back to idle
        offer(4'b0101, 4'b1101);
        i_valid = 1'b0;
        repeat (12) cycle();

        // Three pairs offered back-to-back
        run_len = 0; max_run = 0;
        offer(4'b0011, 4'b1000);
        offer(4'b1110, 4'b0111);
        offer(4'b1001, 4'b0110);
        i_valid = 1'b0;
        repeat (20) cycle();
`ifndef SERIAL_TX_ZERO_FILL_EN
        chk("b2b_run", 32'(max_run), 24);
`endif

        // Freeze for 3 cycles at counter 2
        offer(4'b1011, 4'b0100);
        i_valid = 1'b0;
        wait_pos(2, 0);
        i_en = 1'b0;
        repeat (3) cycle();
        i_en = 1'b1;
        repeat (12) cycle();

        // Reset mid-frame with the pending buffer full
        offer(4'b1111, 4'b1010);
        offer(4'b0110, 4'b1111);
        i_valid = 1'b0;
        wait_pos(5, 1);
        #2 i_rst = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        repeat (2) cycle();
        i_rst = 1'b1;
        repeat (20) cycle();

`ifdef SERIAL_TX_ZERO_FILL_EN
        // One pair followed by zero frames
        offer(4'b0111, 4'b1001);
        i_valid = 1'b0;
        repeat (30) cycle();
        chk("zf_mult_en", 32'(o_mult_en), 1);
`endif

        // Randomized traffic with enable dropouts
        for (int k = 0; k < 400; k++) begin
            i_en     = ($urandom_range(0, 9) != 0);
            i_valid  = $urandom_range(0, 1) == 1;
            i_sample = 4'($urandom);
            i_coeff  = 4'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
